// File: rtl/sub8bit_serial.sv
// Bit-serial 8-bit subtractor (LSB first, one bit per clock); result registered on completion.
// Optional macro SUB8_OVERFLOW_EN adds the two's-complement overflow output Ovf.
module sub8bit_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic [7:0] In1,
  input  logic [7:0] In2,
  input  logic       Bin,
  output logic [7:0] Diff,
  output logic       Bout,
  output logic       Busy,
  output logic       Done
`ifdef SUB8_OVERFLOW_EN
  ,
  output logic       Ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] diff_q, diff_d;
  logic       br_q, br_d;
  logic       bout_q, bout_d;
`ifdef SUB8_OVERFLOW_EN
  logic       ovf_q, ovf_d;
`endif

  logic bit_a, bit_b, bit_d, bit_br;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SUB8_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    // Operands shift right so the bit under work is always at index 0.
    bit_a  = a_q[0];
    bit_b  = b_q[0];
    bit_d  = bit_a ^ bit_b ^ br_q;
    bit_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          a_d     = In1;
          b_d     = In2;
          br_d    = Bin;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[7:1]};
        b_d   = {1'b0, b_q[7:1]};
        br_d  = bit_br;
        sh_d  = {bit_d, sh_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          diff_d  = {bit_d, sh_q[7:1]};
          bout_d  = bit_br;
`ifdef SUB8_OVERFLOW_EN
          ovf_d   = (bit_a ^ bit_b) & (bit_a ^ bit_d);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      sh_q    <= 8'd0;
      diff_q  <= 8'd0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB8_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SUB8_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
`ifdef SUB8_OVERFLOW_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub8bit_serial.sv
// Scoreboard bench for sub8bit_serial: arithmetic reference model, queue of expected results, separate monitor.
module tb_sub8bit_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] In1 = 8'd0;
  logic [7:0] In2 = 8'd0;
  logic       Bin = 1'b0;
  logic [7:0] Diff;
  logic       Bout, Busy, Done;
`ifdef SUB8_OVERFLOW_EN
  logic       Ovf;
`endif

  sub8bit_serial dut (
    .clk(clk), .rst(rst), .Start(Start), .In1(In1), .In2(In2), .Bin(Bin),
    .Diff(Diff), .Bout(Bout), .Busy(Busy), .Done(Done)
`ifdef SUB8_OVERFLOW_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   pend_v = 0;
  int   cyc = 0;
  int   last_acc = -100;
  logic [7:0] held_d = 8'd0;
  logic       held_b = 1'b0;
  logic       held_o = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi, input int due);
    exp_t e;
    int sa, sb, s;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    s  = sa - sb - int'(bi);
    e.diff = 8'((int'(a) - int'(b) - int'(bi)) & 255);
    e.bout = (int'(a) < int'(b) + int'(bi));
    e.ovf  = (s < -128) || (s > 127);
    e.due  = due;
    return e;
  endfunction

  // Reference model: a Start is honoured only when no operation is in its 9-cycle window.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      pend_v   = 0;
      last_acc = -100;
      held_d   = 8'd0;
      held_b   = 1'b0;
      held_o   = 1'b0;
    end else begin
      if (pend_v && cyc == pend.due) begin
        held_d = pend.diff;
        held_b = pend.bout;
        held_o = pend.ovf;
        pend_v = 0;
      end
      if (Start && cyc >= last_acc + 9) begin
        pend   = ref_sub(In1, In2, Bin, cyc + 8);
        pend_v = 1;
        q.push_back(pend);
        last_acc = cyc;
      end
    end
  end

  // Monitor.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      chk("busy", 32'(Busy), 32'((cyc - last_acc >= 0) && (cyc - last_acc <= 7)));
      if (Done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(Done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_time", 32'(cyc), 32'(e.due));
          chk("diff", 32'(Diff), 32'(e.diff));
          chk("bout", 32'(Bout), 32'(e.bout));
`ifdef SUB8_OVERFLOW_EN
          chk("ovf", 32'(Ovf), 32'(e.ovf));
`endif
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("missing_done", 32'(Done), 32'd1);
      end
      chk("diff_hold", 32'(Diff), 32'(held_d));
      chk("bout_hold", 32'(Bout), 32'(held_b));
`ifdef SUB8_OVERFLOW_EN
      chk("ovf_hold", 32'(Ovf), 32'(held_o));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bi);
    Start = 1'b1; In1 = a; In2 = b; Bin = bi;
    tick(1);
    Start = 1'b0; In1 = 8'($urandom); In2 = 8'($urandom); Bin = 1'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    #2;
    chk({tag, "_diff"}, 32'(Diff), 32'd0);
    chk({tag, "_bout"}, 32'(Bout), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    chk_zero("reset");

    op(8'h5A, 8'h23, 1'b0); tick(10);
    chk("basic_diff_const", 32'(Diff), 32'h37);
    op(8'h00, 8'h01, 1'b0); tick(10);
    chk("borrow_diff_const", 32'(Diff), 32'hFF);
    op(8'h80, 8'h00, 1'b1); tick(10);
    chk("bin_diff_const", 32'(Diff), 32'h7F);

    // Start and operand changes mid-run must be ignored.
    op(8'h3C, 8'h15, 1'b1);
    tick(2);
    Start = 1'b1; In1 = 8'hFF; In2 = 8'h01; Bin = 1'b0;
    tick(1);
    Start = 1'b0; In1 = 8'h11;
    tick(10);

    // Back-to-back with Start held high.
    Start = 1'b1;
    for (int i = 0; i < 46; i++) begin
      In1 = 8'($urandom); In2 = 8'($urandom); Bin = 1'($urandom);
      tick(1);
    end
    Start = 1'b0;
    tick(10);

    // Reset in the middle of a run.
    op(8'hC3, 8'h42, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_zero("midrun_reset");
    tick(12);
    op(8'h10, 8'h20, 1'b1); tick(10);

    // Random Start pattern, including Starts during RUN.
    for (int i = 0; i < 300; i++) begin
      Start = 1'($urandom_range(0, 3) == 0);
      In1 = 8'($urandom); In2 = 8'($urandom); Bin = 1'($urandom);
      tick(1);
    end
    Start = 1'b0;
    tick(12);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
